// File: rtl/execute_stage_pkg.sv
// Shared definitions for the execute stage: data width, ALU op codes and FSM/iterative-unit encodings.
package execute_stage_pkg;

  localparam int unsigned DATA_WIDTH = 32;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_MUL  = 4'd10,
    ALU_DIVU = 4'd11,
    ALU_REMU = 4'd12
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_DIV
  } exe_state_e;

  typedef enum logic [1:0] {
    MD_MUL,
    MD_DIVU,
    MD_REMU
  } md_op_e;

  function automatic logic isMultiCycle(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/execute_stage_if.sv
// Decode <-> execute bundle: issued operation and operands in, result/completion/stall out.
interface execute_stage_if import execute_stage_pkg::*; #(
  parameter int unsigned DATA_WIDTH = execute_stage_pkg::DATA_WIDTH
);
  logic                  valid_in;
  logic [3:0]            alu_op;
  logic                  use_imm;
  logic [DATA_WIDTH-1:0] imm;
  logic [DATA_WIDTH-1:0] regA;
  logic [DATA_WIDTH-1:0] regB;
  logic [DATA_WIDTH-1:0] result;
  logic                  instr_complete;
  logic                  busy;

  modport master (
    output valid_in, alu_op, use_imm, imm, regA, regB,
    input  result, instr_complete, busy
  );

  modport slave (
    input  valid_in, alu_op, use_imm, imm, regA, regB,
    output result, instr_complete, busy
  );
endinterface

// File: rtl/execute_stage_iter_muldiv.sv
// Iterative DATA_WIDTH-step unit: LSB-first shift-add multiplier and restoring divider sharing one datapath.
module iter_muldiv import execute_stage_pkg::*; #(
  parameter int unsigned DATA_WIDTH = execute_stage_pkg::DATA_WIDTH
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  input  md_op_e                op,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result
);
  localparam int unsigned CW = $clog2(DATA_WIDTH);

  logic                  active;
  logic [CW-1:0]         count;
  md_op_e                opReg;
  // acc: product accumulator or partial remainder; x: shifted multiplicand or dividend/quotient; y: multiplier or divisor
  logic [DATA_WIDTH-1:0] acc, x, y;
  logic [DATA_WIDTH-1:0] accNext, xNext, yNext;
  logic [DATA_WIDTH:0]   trial;

  always_comb begin
    accNext = acc;
    xNext   = x;
    yNext   = y;
    trial   = '0;
    if (opReg == MD_MUL) begin
      accNext = acc + (y[0] ? x : '0);
      xNext   = x << 1;
      yNext   = y >> 1;
    end else begin
      // Quotient bits shift into x as dividend bits shift out; divide-by-zero yields all-ones / dividend naturally
      trial = {acc, x[DATA_WIDTH-1]};
      if (trial >= {1'b0, y}) begin
        accNext = DATA_WIDTH'(trial - {1'b0, y});
        xNext   = {x[DATA_WIDTH-2:0], 1'b1};
      end else begin
        accNext = trial[DATA_WIDTH-1:0];
        xNext   = {x[DATA_WIDTH-2:0], 1'b0};
      end
    end
  end

  assign done   = active && (count == CW'(DATA_WIDTH - 1));
  assign result = (opReg == MD_DIVU) ? xNext : accNext;

  always_ff @(posedge clock) begin
    if (reset) begin
      active <= 1'b0;
      count  <= '0;
      opReg  <= MD_MUL;
      acc    <= '0;
      x      <= '0;
      y      <= '0;
    end else if (start) begin
      active <= 1'b1;
      count  <= '0;
      opReg  <= op;
      acc    <= '0;
      x      <= a;
      y      <= b;
    end else if (active) begin
      acc   <= accNext;
      x     <= xNext;
      y     <= yNext;
      count <= count + CW'(1);
      if (done) active <= 1'b0;
    end
  end

endmodule

// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU, IDLE/MUL/DIV control FSM and registered result/completion outputs.
module execute_stage import execute_stage_pkg::*; #(
  parameter int unsigned DATA_WIDTH = execute_stage_pkg::DATA_WIDTH
) (
  input  logic           clock,
  input  logic           reset,
  execute_stage_if.slave exeBus
);
  localparam int unsigned SW = $clog2(DATA_WIDTH);

  alu_op_e               op;
  logic [DATA_WIDTH-1:0] opB;
  logic [SW-1:0]         shamt;
  logic [DATA_WIDTH-1:0] aluResult;
  logic [DATA_WIDTH-1:0] mdResult;
  logic [DATA_WIDTH-1:0] resultReg, resultNext;
  logic                  completeReg, completeNext;
  logic                  mdStart, mdDone;
  md_op_e                mdOp;
  exe_state_e            state, stateNext;

  assign op    = alu_op_e'(exeBus.alu_op);
  assign opB   = exeBus.use_imm ? exeBus.imm : exeBus.regB;
  assign shamt = opB[SW-1:0];

  always_comb begin
    aluResult = '0;
    case (op)
      ALU_ADD:  aluResult = exeBus.regA + opB;
      ALU_SUB:  aluResult = exeBus.regA - opB;
      ALU_AND:  aluResult = exeBus.regA & opB;
      ALU_OR:   aluResult = exeBus.regA | opB;
      ALU_XOR:  aluResult = exeBus.regA ^ opB;
      ALU_SLL:  aluResult = exeBus.regA << shamt;
      ALU_SRL:  aluResult = exeBus.regA >> shamt;
      ALU_SRA:  aluResult = $signed(exeBus.regA) >>> shamt;
      ALU_SLT:  aluResult = {{(DATA_WIDTH-1){1'b0}}, ($signed(exeBus.regA) < $signed(opB))};
      ALU_SLTU: aluResult = {{(DATA_WIDTH-1){1'b0}}, (exeBus.regA < opB)};
      default:  aluResult = '0;
    endcase
  end

  iter_muldiv #(.DATA_WIDTH(DATA_WIDTH)) u_muldiv (
    .clock  (clock),
    .reset  (reset),
    .start  (mdStart),
    .op     (mdOp),
    .a      (exeBus.regA),
    .b      (opB),
    .done   (mdDone),
    .result (mdResult)
  );

  always_comb begin
    stateNext    = state;
    resultNext   = resultReg;
    completeNext = 1'b0;
    mdStart      = 1'b0;
    mdOp         = MD_MUL;
    case (state)
      ST_IDLE: begin
        if (exeBus.valid_in) begin
          if (!isMultiCycle(exeBus.alu_op)) begin
            resultNext   = aluResult;
            completeNext = 1'b1;
          end else if (op == ALU_MUL) begin
            mdStart   = 1'b1;
            stateNext = ST_MUL;
          end else begin
            mdStart   = 1'b1;
            mdOp      = (op == ALU_DIVU) ? MD_DIVU : MD_REMU;
            stateNext = ST_DIV;
          end
        end
      end
      ST_MUL, ST_DIV: begin
        if (mdDone) begin
          resultNext   = mdResult;
          completeNext = 1'b1;
          stateNext    = ST_IDLE;
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      resultReg   <= '0;
      completeReg <= 1'b0;
    end else begin
      state       <= stateNext;
      resultReg   <= resultNext;
      completeReg <= completeNext;
    end
  end

  assign exeBus.result         = resultReg;
  assign exeBus.instr_complete = completeReg;
  assign exeBus.busy           = (state != ST_IDLE);

endmodule

// File: doc/execute_stage.md
# execute_stage

Execute stage of the 3-stage pipeline, between decode/GPR read and GPR writeback. Takes registered operands from the GPR memory plus the decoded operation, computes the result, and drives `result` and `instr_complete` into the GPR memory. Single-cycle ALU ops complete in one cycle. MUL/DIVU/REMU run on an iterative 32-step unit and raise `busy` to stall decode.

## Interface
Parameters:
- `DATA_WIDTH`, 32 (from package.v), operand/result width; iteration count equals `DATA_WIDTH`.

Ports:
- `clock` in 1: single clock, all state on posedge.
- `reset` in 1: synchronous, active-high.
- `valid_in` in 1: decode issues an op this cycle; qualifies all inputs below.
- `alu_op` in 4: operation code (package defines).
- `use_imm` in 1: 1 selects `imm` as operand B, 0 selects `regB`.
- `imm` in `DATA_WIDTH`: sign-extended immediate from decode.
- `regA` in `DATA_WIDTH`: operand A from GPR memory.
- `regB` in `DATA_WIDTH`: operand B from GPR memory.
- `result` out `DATA_WIDTH`: registered result; holds until next completion.
- `instr_complete` out 1: one-cycle pulse, `result` valid for GPR write.
- `busy` out 1: multi-cycle op in flight; decode must hold its instruction.

## Operation
- opB = `use_imm` ? `imm` : `regB`. shamt = opB[4:0].
- Op codes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 SLT (signed, result 1/0), 9 SLTU, 10 MUL (low 32 bits of product), 11 DIVU, 12 REMU.
- Codes 13–15 are undefined. They complete as single-cycle ops with `result` = 0.
- Arithmetic is modulo 2^32. No overflow flag.
- DIVU by 0 gives quotient 0xFFFFFFFF. REMU by 0 gives remainder = opA (RISC-V semantics).
- FSM states: IDLE, MUL, DIV.
  - IDLE + `valid_in` + single-cycle op: register result, pulse `instr_complete`, stay IDLE.
  - IDLE + `valid_in` + op 10: latch operands, counter=0, go to MUL.
  - IDLE + `valid_in` + op 11/12: latch operands and op, counter=0, go to DIV.
  - MUL: one shift-add step per cycle. DIV: one restoring step per cycle.
  - When counter reaches 31, that step's result is registered to `result`, `instr_complete` pulses, and the FSM returns to IDLE.
- `busy` = (state != IDLE), decoded from the state register.
- `valid_in` while `busy`=1 is ignored: no acceptance, no side effects.
- Writeback addressing is not handled here. This block only produces `result` and `instr_complete`.

## Timing
- Reset values: `result`=0, `instr_complete`=0, `busy`=0, state=IDLE, counter=0, internal accumulators=0.
- Single-cycle op accepted at edge E0: `result` and `instr_complete`=1 are visible after E0. `instr_complete` is low again after E1 unless another op is accepted at E1.
- Back-to-back single-cycle ops: one per cycle, `instr_complete` stays high continuously.
- Multi-cycle op accepted at E0:
  - `busy`=1 after E0 through E32.
  - Steps execute at E1..E32.
  - `result` and `instr_complete`=1 appear after E32, with `busy`=0 in that same cycle.
- A new op may be accepted at E33, the cycle in which `instr_complete` is high. There is no bubble.
- Operands are sampled only at acceptance. Later changes on `regA`/`regB` do not affect an in-flight op.
- `reset` mid-operation wins over everything: abort to IDLE, no `instr_complete`, `result`=0.
- `result` is never updated without a simultaneous `instr_complete` pulse.

## Structure
- package.v gains `ALU_*` op-code defines (4-bit) and execute FSM state encodings alongside the existing `DATA_WIDTH`.
- Sub-module `iter_muldiv` holds the 32-step shift-add multiplier and restoring divider.
  - Inputs: start, op (mul/divu/remu), a, b.
  - Outputs: done pulse, result.
  - Counter and accumulators live inside it.
- The top level holds the single-cycle ALU mux, the FSM and the output registers.

## Test plan
- Reset then idle: `result`=0, `instr_complete`=0, `busy`=0 for 5 cycles. Assert `reset` mid-MUL (cycle 10): no completion pulse, `busy`=0 next cycle.
- ADD 0x7FFFFFFF + 1 → 0x80000000 in 1 cycle. SUB 0 − 1 → 0xFFFFFFFF. SRA 0x80000000 by imm 4 → 0xF8000000. SLT −1 vs 1 → 1. SLTU same operands → 0. Issue back-to-back: `instr_complete` high 5 consecutive cycles.
- MUL 0x0001_0003 × 0x0002_0005 → 0x000B_000F:
  - `busy` high exactly 32 cycles.
  - `instr_complete` 33 cycles after acceptance.
  - `valid_in` pulses during `busy` are ignored, and `result` is unchanged until completion.
- DIVU 100/7 → 14 and REMU 100/7 → 2. DIVU 5/0 → 0xFFFFFFFF. REMU 5/0 → 5.
- MUL completes, then ADD 2+3 is issued in the completion cycle → 5 the next cycle, no bubble. Opcode 14 → `result` 0 with `instr_complete`.
- Random constrained ops vs. reference model for 10k instructions: checks every `result`, every `instr_complete` timing, and `busy` duration.
